// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester and memory-side signal bundle for mem_port_arbiter.
//               The slave modport is the arbiter; the master modport is the
//               surrounding environment (pipeline stages plus memory).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // fetch port
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    // data port
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    // status
    logic          bus_err;
    logic          stall;
    // memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        input  if_rdata, if_done, dm_rdata, dm_done, bus_err, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
               mem_rdata, mem_ready,
        output if_rdata, if_done, dm_rdata, dm_done, bus_err, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the
//               load/store path. Round-robin on ties, multi-cycle handshake,
//               registered completion, timeout abort with bus_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    localparam int          c_CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_IF_BUSY = 2'd1;
    localparam logic [1:0] c_DM_BUSY = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_last_dm;     // 1 = data port won the last grant
    logic [AW-1:0]   r_mem_addr;
    logic            r_mem_we;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_dm_rdata;
    logic            r_if_done;
    logic            r_dm_done;
    logic            r_bus_err;

    logic            w_if_req;
    logic            w_dm_req;
    logic            w_grant_if;
    logic            w_grant_dm;
    logic            w_ready_hit;
    logic            w_abort;
    logic            w_finish;

    // A requester still holds req during its done cycle; mask it so the
    // finished access is not granted a second time.
    assign w_if_req = bus.if_req & ~r_if_done;
    assign w_dm_req = bus.dm_req & ~r_dm_done;
    assign w_finish = w_ready_hit | w_abort;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grant from IDLE, return to IDLE on completion or abort
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_dm) begin
                    w_next_state = c_DM_BUSY;
                end else if (w_grant_if) begin
                    w_next_state = c_IF_BUSY;
                end
            end
            c_IF_BUSY, c_DM_BUSY: begin
                if (w_finish) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output decode: arbitration in IDLE, ready/timeout detection when busy
    always_comb begin
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        w_ready_hit = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_if_req && w_dm_req) begin
                    w_grant_if = r_last_dm;
                    w_grant_dm = ~r_last_dm;
                end else begin
                    w_grant_if = w_if_req;
                    w_grant_dm = w_dm_req;
                end
            end
            c_IF_BUSY, c_DM_BUSY: begin
                w_ready_hit = bus.mem_ready;
                w_abort     = ~bus.mem_ready && (r_cnt == c_CNT_LAST);
            end
            default: ;
        endcase
    end

    // Datapath: latch granted request, count wait cycles, register completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_last_dm   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            r_bus_err <= 1'b0;

            if (w_grant_dm) begin
                r_mem_addr  <= bus.dm_addr;
                r_mem_we    <= bus.dm_we;
                r_mem_wdata <= bus.dm_wdata;
                r_last_dm   <= 1'b1;
                r_cnt       <= '0;
            end else if (w_grant_if) begin
                r_mem_addr  <= bus.if_addr;
                r_mem_we    <= 1'b0;
                r_mem_wdata <= '0;
                r_last_dm   <= 1'b0;
                r_cnt       <= '0;
            end else if (r_state != c_IDLE && !bus.mem_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_finish) begin
                r_bus_err <= w_abort;
                if (r_state == c_IF_BUSY) begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= w_abort ? '0 : bus.mem_rdata;
                end else begin
                    r_dm_done <= 1'b1;
                    if (w_abort) begin
                        r_dm_rdata <= '0;
                    end else if (!r_mem_we) begin
                        r_dm_rdata <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.mem_en    = (r_state != c_IDLE);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_done   = r_if_done;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.dm_done   = r_dm_done;
    assign bus.bus_err   = r_bus_err;
    assign bus.stall     = w_if_req | w_dm_req;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single-port instruction/data memory between the fetch stage (PC → instruction) and the LD/ST data path (MW, MD=01). Grants one requester at a time, runs a multi-cycle memory handshake, returns read data, and drives the pipeline stall line while any request is outstanding. Includes a timeout that aborts a hung access.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles of mem_en without mem_ready before abort (≥2)
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_done
- if_addr  in  AW  fetch address (PC)
- if_rdata  out  DW  fetched instruction, valid when if_done
- if_done  out  1  one-cycle completion pulse to fetch
- dm_req  in  1  data request, held until dm_done
- dm_we  in  1  1 = store (MW), 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data, valid when dm_done
- dm_done  out  1  one-cycle completion pulse to data path
- bus_err  out  1  pulses with *_done when access aborted by timeout
- stall  out  1  pipeline hold
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory access complete this cycle

## Operation
- States: IDLE, IF_BUSY, DM_BUSY. Reset → IDLE.
- IDLE: sample if_req/dm_req. Only one asserted → grant it. Both → round-robin on last_grant: grant the requester not granted last; last_grant resets to FETCH, so data wins the first tie.
- Grant: register mem_addr/mem_we/mem_wdata from granted requester, mem_en=1, go to *_BUSY, update last_grant. Fetch grant forces mem_we=0, mem_wdata=0.
- *_BUSY: hold mem_* stable. On mem_ready=1: capture mem_rdata into granted requester's rdata (loads and fetches only; stores leave dm_rdata unchanged), pulse its done, drop mem_en, return to IDLE.
- Timeout: cycle counter cleared on grant, increments each BUSY cycle with mem_ready=0. At TIMEOUT-1 with mem_ready still 0: abort — mem_en drops, rdata of granted requester := 0, done and bus_err pulse, → IDLE.
- Requester dropping req before done: access still completes; done still pulses; no new grant from that cycle's dropped req.
- Addresses/data are raw AW/DW pass-through; no arithmetic besides counter (width ≥ clog2(TIMEOUT)).
- stall = (if_req & ~if_done) | (dm_req & ~dm_done), combinational.

## Timing
- Reset values: mem_en, mem_we, if_done, dm_done, bus_err = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; stall follows its equation (0 with reqs low).
- mem_en rises the cycle after req sampled in IDLE.
- mem_ready sampled only while mem_en=1; ignored in IDLE and during reset.
- done/rdata/bus_err registered: appear the cycle after mem_ready (or timeout cycle); done is exactly 1 cycle.
- Min latency req → done: 2 cycles (zero-wait memory, ready in the mem_en cycle).
- Back-to-back: FSM is IDLE in the done cycle; next grant's mem_en the cycle after → min 2-cycle spacing between mem_en assertions.
- Reset mid-access: all state/outputs return to reset values next edge; access is lost, no done.

## Test plan
- Fetch only, zero-wait memory, if_addr=0x10, mem_rdata=0xDEADBEEF → mem_en cycle 1, if_done cycle 2, if_rdata=0xDEADBEEF, stall high cycles 0-1, low cycle 2.
- Simultaneous if_req/dm_req after reset, dm_we=1, dm_addr=0x40, dm_wdata=0x55 → data granted first (mem_we=1, mem_addr=0x40), then fetch; dm_rdata unchanged; both done once.
- Both held continuously, 3 rounds → grants alternate D,F,D,F,D,F.
- Load with mem_ready delayed 5 cycles, mem_rdata=0x1234 → mem_* stable 6 cycles, dm_done on 7th cycle after mem_en rise, dm_rdata=0x1234, bus_err=0.
- mem_ready never asserted, TIMEOUT=4 → mem_en high 4 cycles, then done+bus_err pulse, rdata=0, FSM accepts new req.
- reset asserted during DM_BUSY → next cycle mem_en=0, no dm_done, first subsequent tie granted to data.
